// File: rtl/emitator_date.sv
// emitator_date: transmit side of the sort_val/sort_rdy/sort_data handshake.
// On an accepted start it emits a frame of len words into sort_pipe. The words
// are generated on-chip, starting from SEED.
//
// Build option: define SORT_TX_LFSR_EN to make each next word a Galois LFSR step
// (mask LFSR_TAPS) instead of an increment. With the LFSR, a zero seed becomes 1.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   frame request, sampled only in IDLE
//   len        in   frame length in words, sampled together with start
//   sort_rdy   in   sink ready
//   sort_val   out  word valid
//   sort_data  out  word
//   busy       out  high while in SEND
//   done       out  one-cycle pulse when a frame ends
//   sent_cnt   out  words transferred in the current or last frame
//
// States:
//   IDLE | waiting for start
//   SEND | frame in progress, words offered on sort_val/sort_data
//   DONE | frame complete, done pulse for one cycle
module emitator_date #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned SEED       = 'h10,
  parameter int unsigned LFSR_TAPS  = 'hB8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  sort_rdy,
  output logic                  sort_val,
  output logic [DATA_WIDTH-1:0] sort_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sent_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SEED_W = DATA_WIDTH'(SEED);

`ifdef SORT_TX_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] TAPS_W = DATA_WIDTH'(LFSR_TAPS);
  // All-zero is the LFSR lock-up state, so a zero seed becomes 1.
  localparam logic [DATA_WIDTH-1:0] FIRST_WORD =
    (SEED_W == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : SEED_W;

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [DATA_WIDTH-1:0] d);
    if (d[0]) return (d >> 1) ^ TAPS_W;
    else      return d >> 1;
  endfunction
`else
  localparam logic [DATA_WIDTH-1:0] FIRST_WORD = SEED_W;

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [DATA_WIDTH-1:0] d);
    return d + 1'b1;
  endfunction
`endif

  state_t                r_state, w_state_nx;
  logic                  r_val,   w_val_nx;
  logic [DATA_WIDTH-1:0] r_data,  w_data_nx;
  logic [CNT_WIDTH-1:0]  r_cnt,   w_cnt_nx;
  logic [CNT_WIDTH-1:0]  r_len,   w_len_nx;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_val   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_val   <= w_val_nx;
      r_data  <= w_data_nx;
      r_cnt   <= w_cnt_nx;
      r_len   <= w_len_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_val_nx   = r_val;
    w_data_nx  = r_data;
    w_cnt_nx   = r_cnt;
    w_len_nx   = r_len;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_nx = '0;
          w_len_nx = len;
          if (len != '0) begin
            w_state_nx = S_SEND;
            w_val_nx   = 1'b1;
            w_data_nx  = FIRST_WORD;
          end else begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (r_val && sort_rdy) begin
          w_cnt_nx  = w_cnt_inc;
          w_data_nx = next_word(r_data);
          // The last transfer drops valid on the same edge, so there is no extra word.
          if (w_cnt_inc == r_len) begin
            w_state_nx = S_DONE;
            w_val_nx   = 1'b0;
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_val_nx   = 1'b0;
      end
    endcase
  end

  // Every output comes from a register or from a decode of registered state.
  // sort_rdy therefore has no combinational path to any output.
  assign sort_val  = r_val;
  assign sort_data = r_data;
  assign sent_cnt  = r_cnt;
  assign busy      = (r_state == S_SEND);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_emitator_date.sv
module tb_emitator_date;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int SEED = 'h10;
  localparam int TAPS = 'hB8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          sort_rdy = 1'b0;
  logic          sort_val;
  logic [DW-1:0] sort_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_cnt;

  emitator_date #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .SEED(SEED), .LFSR_TAPS(TAPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sort_rdy(sort_rdy),
    .sort_val(sort_val), .sort_data(sort_data), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int flen_q[$];
  int last_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference word i of a frame, taken directly from the pattern definition.
  function automatic int ref_word(input int i);
`ifdef SORT_TX_LFSR_EN
    int d;
    d = SEED % 256;
    if (d == 0) d = 1;
    for (int k = 0; k < i; k++) d = (d % 2 == 1) ? ((d / 2) ^ TAPS) : (d / 2);
    return d;
`else
    return (SEED + i) % 256;
`endif
  endfunction

  // Monitor / scoreboard
  int prev_val = 0, prev_rdy = 0, prev_data = 0, prev_done = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_val == 1 && prev_rdy == 0) begin
        check("stall_val_hold", int'(sort_val), 1);
        check("stall_data_hold", int'(sort_data), prev_data);
      end
      if (sort_val) check("val_implies_busy", int'(busy), 1);
      if (sort_val && sort_rdy) begin
        if (exp_q.size() == 0) check("unexpected_word", int'(sort_data), -1);
        else check("data", int'(sort_data), exp_q.pop_front());
      end
      if (done) begin
        if (prev_done == 1) check("done_one_cycle", 1, 0);
        if (flen_q.size() == 0) check("unexpected_done", 1, 0);
        else check("sent_cnt_at_done", int'(sent_cnt), flen_q.pop_front());
        check("val_at_done", int'(sort_val), 0);
        check("busy_at_done", int'(busy), 0);
      end
    end
    prev_val  = rst_n ? int'(sort_val) : 0;
    prev_rdy  = int'(sort_rdy);
    prev_data = int'(sort_data);
    prev_done = rst_n ? int'(done) : 0;
  end

  function automatic logic pick_rdy(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;   // bit i -> cycle i: 1,0,0,1,0,1
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return ($urandom_range(0, 3) == 0);
      default: return pat[cyc % 6];
    endcase
  endfunction

  task automatic run_frame(input int l, input int mode, input bit inject);
    int cyc;
    check("sent_cnt_hold", int'(sent_cnt), last_len);
    start = 1'b1;
    len = CW'(l);
    for (int i = 0; i < l; i++) exp_q.push_back(ref_word(i));
    flen_q.push_back(l);
    @(posedge clk); #1;
    start = 1'b0;
    len = CW'($urandom);
    check("busy_after_start", int'(busy), (l != 0) ? 1 : 0);
    check("val_after_start", int'(sort_val), (l != 0) ? 1 : 0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      sort_rdy = pick_rdy(mode, cyc);
      start = inject && (cyc == 1);
      len = CW'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) check("frame_timeout", cyc, -1);
    if (mode == 0) check("frame_cycles", cyc, l);
    last_len = l;
    // A start during the DONE cycle must be ignored.
    start = 1'($urandom_range(0, 1));
    sort_rdy = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_idle", int'(busy), 0);
    check("val_idle", int'(sort_val), 0);
  endtask

  initial begin
    #2;
    check("rst_val", int'(sort_val), 0);
    check("rst_data", int'(sort_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cnt", int'(sent_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(4, 0, 1'b0);     // plain 4-word frame
    run_frame(3, 3, 1'b0);     // fixed ready pattern with stalls
    run_frame(0, 1, 1'b0);     // empty frame
    run_frame(3, 0, 1'b1);     // start pulsed mid-frame
    run_frame(255, 0, 1'b0);   // maximum length, data wraps
    run_frame(1, 1, 1'b1);

    // Reset in the middle of a 5-word frame, after 2 words.
    start = 1'b1;
    len = CW'(5);
    for (int i = 0; i < 5; i++) exp_q.push_back(ref_word(i));
    flen_q.push_back(5);
    sort_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("pre_rst_cnt", int'(sent_cnt), 2);
    rst_n = 1'b0;
    #1;
    check("midrst_val", int'(sort_val), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_cnt", int'(sent_cnt), 0);
    check("midrst_done", int'(done), 0);
    exp_q.delete();
    flen_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_val", int'(sort_val), 0);
    end
    last_len = 0;

    for (int f = 0; f < 40; f++)
      run_frame($urandom_range(0, 20), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    repeat (2) @(posedge clk);
    check("words_left", exp_q.size(), 0);
    check("frames_left", flen_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
